// File: rtl/alu_reservation_station.sv
// alu_reservation_station
//   Buffers dispatched ALU micro-ops until both source operands are known,
//   snoops the CDB for pending tags, and issues one ready op per cycle.
//
// Ports
//   clk_in, rst_in (async, active low), rdy_in (global stall), _clear (flush)
//   _dispatch_*  : upstream op + operand state; _rs_full back-pressure
//   _cdb_*       : result broadcast used for tag wake-up (and dispatch bypass)
//   _alu_full    : downstream back-pressure; _alu_* registered issue outputs
//
// Optional build macro
//   RS_AGE_ORDER_EN : oldest-ready selection through an age matrix.
//                     Undefined -> lowest-index ready entry wins.
module alu_reservation_station #(
  parameter int RS_SIZE   = 8,
  parameter int ROB_WIDTH = 5,
  parameter int OP_WIDTH  = 5
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 _clear,
  input  logic                 _dispatch_valid,
  input  logic [OP_WIDTH-1:0]  _dispatch_op,
  input  logic [ROB_WIDTH-1:0] _dispatch_rob_id,
  input  logic                 _dispatch_rs1_ready,
  input  logic                 _dispatch_rs2_ready,
  input  logic [31:0]          _dispatch_rs1_value,
  input  logic [31:0]          _dispatch_rs2_value,
  input  logic [ROB_WIDTH-1:0] _dispatch_rs1_rob_id,
  input  logic [ROB_WIDTH-1:0] _dispatch_rs2_rob_id,
  output logic                 _rs_full,
  input  logic                 _cdb_ready,
  input  logic [ROB_WIDTH-1:0] _cdb_rob_id,
  input  logic [31:0]          _cdb_value,
  input  logic                 _alu_full,
  output logic                 _alu_ready,
  output logic [ROB_WIDTH-1:0] _alu_rob_id,
  output logic [OP_WIDTH-1:0]  _alu_op,
  output logic [31:0]          _alu_vj,
  output logic [31:0]          _alu_vk
);
  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_SIZE-1:0]                busy_q, busy_d, rj_q, rj_d, rk_q, rk_d;
  logic [RS_SIZE-1:0][OP_WIDTH-1:0]  op_q, op_d;
  logic [RS_SIZE-1:0][ROB_WIDTH-1:0] rob_q, rob_d, qj_q, qj_d, qk_q, qk_d;
  logic [RS_SIZE-1:0][31:0]          vj_q, vj_d, vk_q, vk_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              alu_ready_q, alu_ready_d;
  logic [ROB_WIDTH-1:0]              alu_rob_q, alu_rob_d;
  logic [OP_WIDTH-1:0]               alu_op_q, alu_op_d;
  logic [31:0]                       alu_vj_q, alu_vj_d, alu_vk_q, alu_vk_d;

  logic [RS_SIZE-1:0] elig, sel_vec;
  logic [IDX_W-1:0]   free_idx, issue_idx;
  logic               disp_go, issue_go, byp1, byp2;

  assign _rs_full = (cnt_q == CNT_W'(RS_SIZE));
  assign elig     = busy_q & rj_q & rk_q;
  // A flush swallows any dispatch or issue in the same cycle.
  assign disp_go  = _dispatch_valid && !_rs_full && !_clear;
  assign issue_go = !_alu_full && (|elig) && !_clear;
  assign byp1 = !_dispatch_rs1_ready && _cdb_ready && (_cdb_rob_id == _dispatch_rs1_rob_id);
  assign byp2 = !_dispatch_rs2_ready && _cdb_ready && (_cdb_rob_id == _dispatch_rs2_rob_id);

  // Lowest free slot / lowest selected slot: descending scan, last hit wins.
  always_comb begin
    free_idx  = '0;
    issue_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i])  free_idx  = IDX_W'(i);
      if (sel_vec[i])  issue_idx = IDX_W'(i);
    end
  end

`ifdef RS_AGE_ORDER_EN
  // older_q[j][i] = 1 : entry j was dispatched before entry i.
  logic [RS_SIZE-1:0][RS_SIZE-1:0] older_q, older_d;

  always_comb begin
    older_d = older_q;
    if (_clear) begin
      older_d = '0;
    end else if (disp_go) begin
      for (int j = 0; j < RS_SIZE; j++) older_d[j][free_idx] = busy_q[j];
      older_d[free_idx] = '0;
    end
    // Keep only ready entries with no older ready entry.
    sel_vec = elig;
    for (int i = 0; i < RS_SIZE; i++)
      for (int j = 0; j < RS_SIZE; j++)
        if (elig[j] && older_q[j][i]) sel_vec[i] = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     older_q <= '0;
    else if (rdy_in) older_q <= older_d;
  end
`else
  assign sel_vec = elig;
`endif

  always_comb begin
    busy_d = busy_q; rj_d = rj_q; rk_d = rk_q; op_d = op_q; rob_d = rob_q;
    qj_d = qj_q; qk_d = qk_q; vj_d = vj_q; vk_d = vk_q;
    cnt_d = cnt_q;
    alu_ready_d = 1'b0;
    alu_rob_d = alu_rob_q; alu_op_d = alu_op_q; alu_vj_d = alu_vj_q; alu_vk_d = alu_vk_q;

    // CDB wake-up; eligibility is from registered state, so a capture here
    // can only issue next cycle.
    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy_q[i] && _cdb_ready) begin
        if (!rj_q[i] && qj_q[i] == _cdb_rob_id) begin rj_d[i] = 1'b1; vj_d[i] = _cdb_value; end
        if (!rk_q[i] && qk_q[i] == _cdb_rob_id) begin rk_d[i] = 1'b1; vk_d[i] = _cdb_value; end
      end
    end

    if (issue_go) begin
      busy_d[issue_idx] = 1'b0;
      alu_ready_d = 1'b1;
      alu_rob_d   = rob_q[issue_idx];
      alu_op_d    = op_q[issue_idx];
      alu_vj_d    = vj_q[issue_idx];
      alu_vk_d    = vk_q[issue_idx];
    end

    // free_idx comes from busy_q, so a slot freed by issue is not reused now.
    if (disp_go) begin
      busy_d[free_idx] = 1'b1;
      op_d[free_idx]   = _dispatch_op;
      rob_d[free_idx]  = _dispatch_rob_id;
      qj_d[free_idx]   = _dispatch_rs1_rob_id;
      qk_d[free_idx]   = _dispatch_rs2_rob_id;
      rj_d[free_idx]   = _dispatch_rs1_ready | byp1;
      rk_d[free_idx]   = _dispatch_rs2_ready | byp2;
      vj_d[free_idx]   = _dispatch_rs1_ready ? _dispatch_rs1_value : _cdb_value;
      vk_d[free_idx]   = _dispatch_rs2_ready ? _dispatch_rs2_value : _cdb_value;
    end

    cnt_d = cnt_q + CNT_W'(disp_go) - CNT_W'(issue_go);

    if (_clear) begin
      busy_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q <= '0; rj_q <= '0; rk_q <= '0; op_q <= '0; rob_q <= '0;
      qj_q <= '0; qk_q <= '0; vj_q <= '0; vk_q <= '0; cnt_q <= '0;
      alu_ready_q <= 1'b0; alu_rob_q <= '0; alu_op_q <= '0;
      alu_vj_q <= '0; alu_vk_q <= '0;
    end else if (rdy_in) begin
      busy_q <= busy_d; rj_q <= rj_d; rk_q <= rk_d; op_q <= op_d; rob_q <= rob_d;
      qj_q <= qj_d; qk_q <= qk_d; vj_q <= vj_d; vk_q <= vk_d; cnt_q <= cnt_d;
      alu_ready_q <= alu_ready_d; alu_rob_q <= alu_rob_d; alu_op_q <= alu_op_d;
      alu_vj_q <= alu_vj_d; alu_vk_q <= alu_vk_d;
    end
  end

  assign _alu_ready  = alu_ready_q;
  assign _alu_rob_id = alu_rob_q;
  assign _alu_op     = alu_op_q;
  assign _alu_vj     = alu_vj_q;
  assign _alu_vk     = alu_vk_q;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station (RS_SIZE=8).
// Inputs change 1ns after the rising edge; outputs are checked at that same
// point, so each check sees the state produced by the edge just passed.
module tb_alu_reservation_station;
  logic        clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, clear = 1'b0;
  logic        dvalid = 1'b0, r1rdy = 1'b0, r2rdy = 1'b0;
  logic [4:0]  dop = '0, drob = '0, q1 = '0, q2 = '0;
  logic [31:0] v1 = '0, v2 = '0;
  logic        rs_full, cdb_rdy = 1'b0, alu_full = 1'b0, alu_ready;
  logic [4:0]  cdb_rob = '0, alu_rob, alu_op;
  logic [31:0] cdb_val = '0, alu_vj, alu_vk;
  int          n_tests = 0, n_fail = 0;

  alu_reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(clear),
    ._dispatch_valid(dvalid), ._dispatch_op(dop), ._dispatch_rob_id(drob),
    ._dispatch_rs1_ready(r1rdy), ._dispatch_rs2_ready(r2rdy),
    ._dispatch_rs1_value(v1), ._dispatch_rs2_value(v2),
    ._dispatch_rs1_rob_id(q1), ._dispatch_rs2_rob_id(q2),
    ._rs_full(rs_full), ._cdb_ready(cdb_rdy), ._cdb_rob_id(cdb_rob),
    ._cdb_value(cdb_val), ._alu_full(alu_full), ._alu_ready(alu_ready),
    ._alu_rob_id(alu_rob), ._alu_op(alu_op), ._alu_vj(alu_vj), ._alu_vk(alu_vk));

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic disp(input logic [4:0] op, input logic [4:0] rob,
                      input logic a_rdy, input logic [31:0] a_v, input logic [4:0] a_q,
                      input logic b_rdy, input logic [31:0] b_v, input logic [4:0] b_q);
    dvalid = 1'b1; dop = op; drob = rob;
    r1rdy = a_rdy; v1 = a_v; q1 = a_q; r2rdy = b_rdy; v2 = b_v; q2 = b_q;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] val);
    cdb_rdy = 1'b1; cdb_rob = tag; cdb_val = val;
  endtask

  task automatic idle();
    dvalid = 1'b0; cdb_rdy = 1'b0; clear = 1'b0;
  endtask

  task automatic issue_chk(input string tag, input logic [4:0] rob, input logic [31:0] vj);
    chk({tag, "_rdy"}, 32'(alu_ready), 32'd1);
    chk({tag, "_rob"}, 32'(alu_rob), 32'(rob));
    chk({tag, "_vj"},  alu_vj, vj);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_ready", 32'(alu_ready), 32'd0);
    chk("rst_full",  32'(rs_full),   32'd0);
    chk("rst_rob",   32'(alu_rob),   32'd0);
    rst_in = 1'b1;
    tick(); tick();
    chk("idle_ready", 32'(alu_ready), 32'd0);
    chk("idle_full",  32'(rs_full),   32'd0);

    // Both operands ready: issue one edge after dispatch, one-cycle pulse
    disp(5'd3, 5'd3, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0);
    tick(); idle();
    chk("add_resident", 32'(alu_ready), 32'd0);
    tick();
    issue_chk("add", 5'd3, 32'd5);
    chk("add_vk", alu_vk, 32'd7);
    chk("add_op", 32'(alu_op), 32'd3);
    tick();
    chk("add_pulse", 32'(alu_ready), 32'd0);

    // rs1 waits on tag 9; captured CDB value issues the cycle after capture
    disp(5'd1, 5'd4, 1'b0, 32'd0, 5'd9, 1'b1, 32'd2, 5'd0);
    tick(); idle();
    tick();
    chk("wait_noissue", 32'(alu_ready), 32'd0);
    cdb(5'd9, 32'h1234);
    tick(); idle();
    chk("cdb_capture_latency", 32'(alu_ready), 32'd0);
    tick();
    issue_chk("cdb", 5'd4, 32'h1234);
    chk("cdb_vk", alu_vk, 32'd2);
    tick();

    // Dispatch bypass on rs1, later wake-up on rs2
    disp(5'd2, 5'd5, 1'b0, 32'd0, 5'd10, 1'b0, 32'd0, 5'd11);
    cdb(5'd10, 32'hAA);
    tick(); idle();
    tick();
    chk("byp_half", 32'(alu_ready), 32'd0);
    cdb(5'd11, 32'hBB);
    tick(); idle();
    chk("byp_latency", 32'(alu_ready), 32'd0);
    tick();
    issue_chk("byp", 5'd5, 32'hAA);
    chk("byp_vk", alu_vk, 32'hBB);
    tick();

    // Fill all 8 entries (rob 16+i waiting on tag 20+i)
    for (int i = 0; i < 8; i++) begin
      disp(5'd0, 5'(16 + i), 1'b0, 32'd0, 5'(20 + i), 1'b1, 32'd0, 5'd0);
      tick();
    end
    idle();
    chk("full_set", 32'(rs_full), 32'd1);
    disp(5'd0, 5'd30, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0);  // dropped
    tick(); idle();
    chk("full_hold", 32'(rs_full), 32'd1);
    tick();
    chk("drop_noissue", 32'(alu_ready), 32'd0);
    cdb(5'd22, 32'h55);
    tick(); idle();
    chk("full_after_cap", 32'(rs_full), 32'd1);
    tick();
    issue_chk("full_res", 5'd18, 32'h55);
    chk("full_drop", 32'(rs_full), 32'd0);
    tick();
    chk("full_res_pulse", 32'(alu_ready), 32'd0);

    // Make slot 0 ready, then flush on the cycle its issue would happen
    cdb(5'd20, 32'h1);
    tick(); idle();
    clear = 1'b1;
    tick(); idle();
    chk("clr_ready", 32'(alu_ready), 32'd0);
    chk("clr_full",  32'(rs_full),   32'd0);
    for (int t = 21; t < 28; t++) begin
      cdb(5'(t), 32'h9);
      tick();
      chk("clr_cdb_noissue", 32'(alu_ready), 32'd0);
    end
    idle(); tick();
    chk("clr_cdb_noissue_last", 32'(alu_ready), 32'd0);

    // Arrange ready entries in slots 5, 1, 3 (dispatch order)
    for (int i = 0; i < 6; i++) begin
      disp(5'd0, 5'(10 + i), 1'b0, 32'd0, 5'(i + 1), 1'b1, 32'd0, 5'd0);
      tick();
    end
    idle();
    cdb(5'd2, 32'h2);
    tick();
    cdb(5'd4, 32'h4);
    tick(); idle();
    issue_chk("free_s1", 5'd11, 32'h2);
    tick();
    issue_chk("free_s3", 5'd13, 32'h4);
    tick();
    chk("free_done", 32'(alu_ready), 32'd0);
    alu_full = 1'b1;
    disp(5'd0, 5'd22, 1'b1, 32'h22, 5'd0, 1'b1, 32'd0, 5'd0);  // slot 1
    tick();
    disp(5'd0, 5'd23, 1'b1, 32'h23, 5'd0, 1'b1, 32'd0, 5'd0);  // slot 3
    tick(); idle();
    cdb(5'd6, 32'h66);                                          // slot 5 ready
    tick(); idle();
    tick();
    chk("aluf_hold1", 32'(alu_ready), 32'd0);
    tick();
    chk("aluf_hold2", 32'(alu_ready), 32'd0);
    alu_full = 1'b0;
`ifdef RS_AGE_ORDER_EN
    tick(); issue_chk("ord0", 5'd15, 32'h66);
    tick(); issue_chk("ord1", 5'd22, 32'h22);
    tick(); issue_chk("ord2", 5'd23, 32'h23);
`else
    tick(); issue_chk("ord0", 5'd22, 32'h22);
    tick(); issue_chk("ord1", 5'd23, 32'h23);
    tick(); issue_chk("ord2", 5'd15, 32'h66);
`endif
    tick();
    chk("ord_done", 32'(alu_ready), 32'd0);

    // Stall: slots 0,2,4 still wait on tags 1,3,5; add a ready op to slot 1
    alu_full = 1'b1;
    disp(5'd0, 5'd7, 1'b1, 32'd9, 5'd0, 1'b1, 32'd8, 5'd0);
    tick(); idle();
    rdy_in = 1'b0; alu_full = 1'b0;
    cdb(5'd1, 32'h77);  // must not be captured by slot 0
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_noissue", 32'(alu_ready), 32'd0);
    end
    rdy_in = 1'b1; idle();
    tick();
    issue_chk("stall_rel", 5'd7, 32'd9);
    tick();
    chk("stall_nocap", 32'(alu_ready), 32'd0);

    // Async reset mid-cycle while an issue pulse is high
    cdb(5'd1, 32'h78);
    tick(); idle();
    tick();
    issue_chk("pre_rst", 5'd10, 32'h78);
    #2 rst_in = 1'b0;
    #1;
    chk("arst_ready", 32'(alu_ready), 32'd0);
    chk("arst_rob",   32'(alu_rob),   32'd0);
    chk("arst_vj",    alu_vj,         32'd0);
    chk("arst_vk",    alu_vk,         32'd0);
    chk("arst_op",    32'(alu_op),    32'd0);
    chk("arst_full",  32'(rs_full),   32'd0);
    tick();
    rst_in = 1'b1;
    cdb(5'd3, 32'h3);
    tick();
    cdb(5'd5, 32'h5);
    tick(); idle();
    tick();
    chk("arst_discard", 32'(alu_ready), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
